// File: rtl/mips_arb_pkg.sv
// rtl/mips_arb_pkg.sv - Shared types and constants for the I/D memory arbiter
package mips_arb_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Requester identifiers, also the bit index of each port in a grant vector
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Width of the WAIT-phase latency counter for a given memory latency
  function automatic int lat_cnt_w(input int mem_lat);
    return (mem_lat < 1) ? 1 : $clog2(mem_lat + 1);
  endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - Requester and memory-side signal bundle for the arbiter
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_rsp_valid;
  logic [DATA_W-1:0] i_rsp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    input  mem_rdata,
    output i_req_ready, i_rsp_valid, i_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    output mem_rdata,
    input  i_req_ready, i_rsp_valid, i_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips_rr_arbiter2.sv
// rtl/mips_rr_arbiter2.sv - Two-way round-robin arbiter with one-hot grant
module mips_rr_arbiter2
  import mips_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  // Lone requester wins outright; on contention the pointer picks the winner
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = (ptr_q == PORT_D) ? 2'b10 : 2'b01;
    end
  end

  // After any accepted grant, favour the port that did not just win
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = grant_o[1] ? PORT_I : PORT_D;
    end
  end

  // Pointer register, favours the fetch port out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= PORT_I;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - Round-robin I/D arbiter for one unified memory (optional stats: MIPS_ARB_STATS_EN)
module mips_mem_arbiter
  import mips_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  mips_mem_arbiter_if.slave bus,
  output logic [31:0]       stat_i_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_conflicts
);

  localparam int               CNT_W    = lat_cnt_w(MEM_LAT);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_data_q, i_data_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0] req;
  logic [1:0] grant;
  logic       idle_ok;
  logic       hs_i;
  logic       hs_d;
  logic       unused_addr_lsbs;

  assign req     = {bus.d_req_valid, bus.i_req_valid};
  assign idle_ok = (state_q == IDLE) && !reset;

  assign bus.i_req_ready = idle_ok & grant[PORT_I];
  assign bus.d_req_ready = idle_ok & grant[PORT_D];
  assign hs_i            = bus.i_req_valid & bus.i_req_ready;
  assign hs_d            = bus.d_req_valid & bus.d_req_ready;

  // Memory is word addressed; byte offsets are simply discarded
  assign unused_addr_lsbs = ^{bus.i_req_addr[1:0], bus.d_req_addr[1:0]};

  mips_rr_arbiter2 u_rr (
    .clk_i     (clock),
    .rst_i     (reset),
    .req_i     (req),
    .advance_i (hs_i | hs_d),
    .grant_o   (grant)
  );

  // Sequencer: capture on handshake, strobe memory once, wait out latency, pulse response
  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    i_data_d = i_data_q;
    d_data_d = d_data_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hs_i) begin
          port_d  = PORT_I;
          we_d    = 1'b0;
          addr_d  = bus.i_req_addr[ADDR_W-1:2];
          wdata_d = '0;
          state_d = ISSUE;
        end else if (hs_d) begin
          port_d  = PORT_D;
          we_d    = bus.d_req_we;
          addr_d  = bus.d_req_addr[ADDR_W-1:2];
          wdata_d = bus.d_req_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (port_q == PORT_I) begin
            i_data_d = bus.mem_rdata;
          end else begin
            d_data_d = we_q ? '0 : bus.mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      port_q   <= PORT_I;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      i_data_q <= '0;
      d_data_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      i_data_q <= i_data_d;
      d_data_q <= d_data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.mem_en      = (state_q == ISSUE);
  assign bus.mem_we      = (state_q == ISSUE) & we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.i_rsp_valid = (state_q == RESP) && (port_q == PORT_I);
  assign bus.d_rsp_valid = (state_q == RESP) && (port_q == PORT_D);
  assign bus.i_rsp_data  = i_data_q;
  assign bus.d_rsp_data  = d_data_q;

`ifdef MIPS_ARB_STATS_EN
  logic [31:0] stat_i_q;
  logic [31:0] stat_d_q;
  logic [31:0] stat_c_q;

  // Per-port grant counts and contended idle cycles, free-running with wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_i_q <= '0;
      stat_d_q <= '0;
      stat_c_q <= '0;
    end else begin
      if (hs_i) begin
        stat_i_q <= stat_i_q + 32'd1;
      end
      if (hs_d) begin
        stat_d_q <= stat_d_q + 32'd1;
      end
      if ((state_q == IDLE) && (req == 2'b11)) begin
        stat_c_q <= stat_c_q + 32'd1;
      end
    end
  end

  assign stat_i_grants  = stat_i_q;
  assign stat_d_grants  = stat_d_q;
  assign stat_conflicts = stat_c_q;
`else
  assign stat_i_grants  = '0;
  assign stat_d_grants  = '0;
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - Scoreboard bench for the I/D memory arbiter
module tb_mips_mem_arbiter;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } rsp_t;

`ifdef MIPS_ARB_STATS_EN
  localparam logic [31:0] EXP_STAT = 32'd3;
`else
  localparam logic [31:0] EXP_STAT = 32'd0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  logic [31:0] si1, sd1, sc1, si3, sd3, sc3;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus1),
    .stat_i_grants  (si1),
    .stat_d_grants  (sd1),
    .stat_conflicts (sc1)
  );

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus3),
    .stat_i_grants  (si3),
    .stat_d_grants  (sd3),
    .stat_conflicts (sc3)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   rsp_cyc = 0;
  rsp_t sb[$];
  logic grant_log[$];
  rsp_t mon_e;
  bit   auto_i = 0;
  bit   auto_d = 0;
  bit   no_sb = 0;
  logic [31:0] shadow [64];

  function automatic logic [31:0] init_word(input logic [5:0] a);
    return (a == 6'd4) ? 32'h2008_0005 : {24'hA5A5A5, 2'b00, a};
  endfunction

  // Memory models: latency 1 with writes, latency 3 read-only pipeline
  logic [31:0] mem1 [64];
  logic [63:0] wr1 = '0;
  logic [31:0] pipe3 [3];

  always @(posedge clock) begin
    if (bus1.mem_en) begin
      if (bus1.mem_we) begin
        mem1[bus1.mem_addr[5:0]] <= bus1.mem_wdata;
        wr1[bus1.mem_addr[5:0]]  <= 1'b1;
      end
      bus1.mem_rdata <= wr1[bus1.mem_addr[5:0]] ? mem1[bus1.mem_addr[5:0]] : init_word(bus1.mem_addr[5:0]);
    end
  end

  always @(posedge clock) begin
    if (bus3.mem_en) pipe3[0] <= init_word(bus3.mem_addr[5:0]);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus3.mem_rdata = pipe3[2];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (bus1.i_rsp_valid === 1'b1 || bus1.d_rsp_valid === 1'b1) begin
      rsp_cyc = cyc;
      check("rsp_both", 32'(bus1.i_rsp_valid & bus1.d_rsp_valid), 32'd0);
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL rsp_unexpected: observed i=%b d=%b expected no response", bus1.i_rsp_valid, bus1.d_rsp_valid);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("rsp_port", 32'(bus1.d_rsp_valid), 32'(mon_e.port));
        check("rsp_data", bus1.d_rsp_valid ? bus1.d_rsp_data : bus1.i_rsp_data, mon_e.data);
      end
    end
  end

  // One clock of the dut1 requester: log handshakes, predict results, update payloads
  task automatic cycle();
    logic hi, hd;
    @(negedge clock);
    hi = ((bus1.i_req_valid & bus1.i_req_ready) === 1'b1);
    hd = ((bus1.d_req_valid & bus1.d_req_ready) === 1'b1);
    if (hi || hd) hs_cyc = cyc;
    if (hi) begin
      grant_log.push_back(1'b0);
      if (!no_sb) sb.push_back('{1'b0, shadow[bus1.i_req_addr[7:2]]});
    end
    if (hd) begin
      grant_log.push_back(1'b1);
      if (!no_sb) begin
        if (bus1.d_req_we) begin
          shadow[bus1.d_req_addr[7:2]] = bus1.d_req_wdata;
          sb.push_back('{1'b1, 32'd0});
        end else begin
          sb.push_back('{1'b1, shadow[bus1.d_req_addr[7:2]]});
        end
      end
    end
    @(posedge clock);
    #1;
    if (hi) begin
      if (auto_i) bus1.i_req_addr = bus1.i_req_addr + 32'd4;
      else bus1.i_req_valid = 1'b0;
    end
    if (hd) begin
      if (auto_d) bus1.d_req_addr = bus1.d_req_addr + 32'd4;
      else bus1.d_req_valid = 1'b0;
    end
  endtask

  task automatic wait_grants(input int n, input int bound, input string tag);
    int k = 0;
    while (grant_log.size() < n && k < bound) begin
      cycle();
      k++;
    end
    n_vec++;
    assert (grant_log.size() >= n) else begin
      n_err++;
      $error("FAIL %s_timeout: observed %0d grants expected %0d", tag, grant_log.size(), n);
    end
  endtask

  task automatic wait_drain(input int bound, input string tag);
    int k = 0;
    while (sb.size() != 0 && k < bound) begin
      cycle();
      k++;
    end
    n_vec++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL %s_drain: observed %0d pending expected 0", tag, sb.size());
    end
    cycle();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    bus1.i_req_valid = 1'b0;
    bus1.d_req_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n0;
    for (int a = 0; a < 64; a++) shadow[a] = init_word(6'(a));
    {bus1.i_req_valid, bus1.d_req_valid, bus1.d_req_we} = '0;
    {bus1.i_req_addr, bus1.d_req_addr, bus1.d_req_wdata} = '0;
    {bus3.i_req_valid, bus3.d_req_valid, bus3.d_req_we} = '0;
    {bus3.i_req_addr, bus3.d_req_addr, bus3.d_req_wdata} = '0;

    // Reset state, with both requests raised to show ready stays low
    reset = 1'b1;
    bus1.i_req_valid = 1'b1;
    bus1.d_req_valid = 1'b1;
    @(posedge clock);
    #1;
    check("rst_i_ready", 32'(bus1.i_req_ready), 32'd0);
    check("rst_d_ready", 32'(bus1.d_req_ready), 32'd0);
    check("rst_mem_en", 32'(bus1.mem_en), 32'd0);
    check("rst_mem_addr", 32'(bus1.mem_addr), 32'd0);
    check("rst_rsp", 32'({bus1.i_rsp_valid, bus1.d_rsp_valid}), 32'd0);
    check("rst_stats", si1 | sd1 | sc1, 32'd0);
    pulse_reset();

    // Three contended rounds: I wins, then D alone
    bus1.i_req_addr = 32'h0;  bus1.i_req_valid = 1'b1;
    bus1.d_req_addr = 32'h80; bus1.d_req_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      n0 = grant_log.size();
      wait_grants(n0 + 1, 20, "stat_i");
      check("stat_round_i", 32'(grant_log[n0]), 32'd0);
      wait_grants(n0 + 2, 20, "stat_d");
      check("stat_round_d", 32'(grant_log[n0 + 1]), 32'd1);
      if (r < 2) begin
        bus1.i_req_addr = 32'(4 * (r + 1));        bus1.i_req_valid = 1'b1;
        bus1.d_req_addr = 32'(32'h80 + 4 * (r + 1)); bus1.d_req_valid = 1'b1;
      end
    end
    wait_drain(20, "stat");
    check("stat_i_grants", si1, EXP_STAT);
    check("stat_d_grants", sd1, EXP_STAT);
    check("stat_conflicts", sc1, EXP_STAT);

    // Continuous contention from reset: strict alternation starting with I
    pulse_reset();
    grant_log.delete();
    auto_i = 1; auto_d = 1;
    bus1.i_req_addr = 32'h0;  bus1.i_req_valid = 1'b1;
    bus1.d_req_addr = 32'h80; bus1.d_req_valid = 1'b1;
    wait_grants(8, 60, "alt");
    auto_i = 0; auto_d = 0;
    bus1.i_req_valid = 1'b0;
    bus1.d_req_valid = 1'b0;
    for (int k = 0; k < 8; k++) check($sformatf("alt_grant%0d", k), 32'(grant_log[k]), 32'(k & 1));
    wait_drain(20, "alt");

    // I-only fetch of word 4
    n0 = grant_log.size();
    bus1.i_req_addr = 32'h10; bus1.i_req_valid = 1'b1;
    wait_grants(n0 + 1, 20, "fetch");
    @(negedge clock);
    check("fetch_mem_en", 32'(bus1.mem_en), 32'd1);
    check("fetch_mem_addr", 32'(bus1.mem_addr), 32'd4);
    check("fetch_mem_we", 32'(bus1.mem_we), 32'd0);
    wait_drain(20, "fetch");
    check("fetch_latency", 32'(rsp_cyc - hs_cyc), 32'd3);
    check("fetch_data_held", bus1.i_rsp_data, 32'h2008_0005);

    // Store then load at 0x40
    n0 = grant_log.size();
    bus1.d_req_addr = 32'h40; bus1.d_req_we = 1'b1; bus1.d_req_wdata = 32'hDEAD_BEEF;
    bus1.d_req_valid = 1'b1;
    wait_grants(n0 + 1, 20, "store");
    @(negedge clock);
    check("store_mem_en", 32'(bus1.mem_en), 32'd1);
    check("store_mem_we", 32'(bus1.mem_we), 32'd1);
    check("store_mem_addr", 32'(bus1.mem_addr), 32'h10);
    check("store_mem_wdata", bus1.mem_wdata, 32'hDEAD_BEEF);
    wait_drain(20, "store");
    check("store_ack_data", bus1.d_rsp_data, 32'd0);
    bus1.d_req_we = 1'b0;
    bus1.d_req_valid = 1'b1;
    wait_grants(n0 + 2, 20, "load");
    wait_drain(20, "load");
    check("load_data", bus1.d_rsp_data, 32'hDEAD_BEEF);

    // Reset during WAIT of a D load drops the response
    no_sb = 1;
    n0 = grant_log.size();
    bus1.d_req_addr = 32'h84; bus1.d_req_valid = 1'b1;
    wait_grants(n0 + 1, 20, "rstwait");
    cycle();
    bus1.d_req_valid = 1'b1;
    reset = 1'b1;
    #1;
    check("rw_mem_en", 32'(bus1.mem_en), 32'd0);
    check("rw_mem_addr", 32'(bus1.mem_addr), 32'd0);
    check("rw_mem_wdata", bus1.mem_wdata, 32'd0);
    check("rw_i_rsp_data", bus1.i_rsp_data, 32'd0);
    check("rw_d_rsp_data", bus1.d_rsp_data, 32'd0);
    check("rw_d_ready", 32'(bus1.d_req_ready), 32'd0);
    check("rw_rsp", 32'({bus1.i_rsp_valid, bus1.d_rsp_valid}), 32'd0);
    no_sb = 0;
    pulse_reset();
    repeat (6) cycle();
    n0 = grant_log.size();
    bus1.i_req_addr = 32'h8;  bus1.i_req_valid = 1'b1;
    bus1.d_req_addr = 32'h88; bus1.d_req_valid = 1'b1;
    wait_grants(n0 + 1, 20, "post_rst");
    bus1.d_req_valid = 1'b0;
    check("post_rst_first", 32'(grant_log[n0]), 32'd0);
    wait_drain(20, "post_rst");

    // MEM_LAT=3 fetch: response 5 cycles after handshake, no ready while busy
    bus3.i_req_addr = 32'h10; bus3.i_req_valid = 1'b1;
    n0 = -1;
    for (int k = 0; k < 10 && n0 < 0; k++) begin
      @(negedge clock);
      if (bus3.i_req_ready === 1'b1) n0 = cyc;
    end
    check("lat3_handshake", 32'(n0 >= 0), 32'd1);
    @(posedge clock);
    #1;
    bus3.d_req_valid = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clock);
      check($sformatf("lat3_ready%0d", j), 32'({bus3.i_req_ready, bus3.d_req_ready}), 32'd0);
      check($sformatf("lat3_rsp%0d", j), 32'({bus3.i_rsp_valid, bus3.d_rsp_valid}), (j == 5) ? 32'd2 : 32'd0);
    end
    check("lat3_latency", 32'(cyc - n0), 32'd5);
    check("lat3_data", bus3.i_rsp_data, 32'h2008_0005);
    @(posedge clock);
    #1;
    bus3.i_req_valid = 1'b0;
    bus3.d_req_valid = 1'b0;
    repeat (3) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the core's instruction-fetch port (I) and load/store port (D).
- Round-robin grant, one outstanding transaction at a time, valid/ready request handshake, one-cycle response pulse.
- Sits between mips_core and the unified memory model; lets the core move to a multi-cycle implementation without separate instruction and data memories.

Parameters:
- ADDR_W, 32, byte address width of both requester ports.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (≥1); mem_rdata is valid MEM_LAT edges after the edge that samples mem_en.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  fetch request.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_req_addr  in  ADDR_W  fetch byte address.
- i_rsp_valid  out  1  fetch data valid (1-cycle pulse).
- i_rsp_data  out  DATA_W  fetched word.
- d_req_valid  in  1  load/store request.
- d_req_ready  out  1  load/store accepted.
- d_req_we  in  1  1 = store.
- d_req_addr  in  ADDR_W  load/store byte address.
- d_req_wdata  in  DATA_W  store data.
- d_rsp_valid  out  1  load data or store ack (1-cycle pulse).
- d_rsp_data  out  DATA_W  load data; 0 for a store ack.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W-2  word address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data.
- stat_i_grants, stat_d_grants, stat_conflicts  out  32 each  statistics (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state):
  - All outputs 0; FSM to IDLE; round-robin pointer favours I.
  - Any in-flight transaction is dropped: no rsp pulse is issued for it.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Exactly one of i_req_ready/d_req_ready is high, and only when that port's valid is high.
  - Ready is combinational from valid and the pointer; no ready is asserted in any other state.
  - Grant rule: if only one valid, grant it. If both valid, grant the port the pointer favours, then point the pointer at the other port.
  - A single-requester grant also moves the pointer to the other port.
  - On a handshake (valid & ready), capture port id, we, addr, wdata; go to ISSUE.
- Requester obligation: hold valid and payload stable until ready. Dropping valid before ready is legal and cancels the request.
- ISSUE (1 cycle):
  - mem_en=1, mem_we=captured we, mem_addr=addr[ADDR_W-1:2], mem_wdata=captured wdata.
  - addr[1:0] is ignored (no misalignment trap).
- WAIT: lasts MEM_LAT cycles. mem_en=0; mem_addr and mem_wdata hold their values. On the last WAIT edge, register mem_rdata into the response data (0 if write).
- RESP (1 cycle): the owning port's rsp_valid=1 with the registered data; the other port's rsp_valid stays 0.
- Latency: handshake in cycle N gives rsp_valid in cycle N+2+MEM_LAT. The next handshake is possible in cycle N+3+MEM_LAT. Peak throughput is one access per MEM_LAT+3 cycles.
- rsp_data holds its last value after the pulse; only rsp_valid qualifies it.
- Writes need a WAIT as well (uniform timing); store ack uses d_rsp_valid with d_rsp_data=0.
- I port never writes; mem_we=0 for every I transaction.

Optional Feature:
- Macro MIPS_ARB_STATS_EN.
- Defined:
  - stat_i_grants and stat_d_grants increment on each handshake of that port.
  - stat_conflicts increments on each IDLE cycle with both valids high.
  - All three are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: the three ports are still present, tied to 0, and no counter flops are synthesised.

Decomposition:
- Package mips_arb_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP).
  - Port id constants PORT_I=0, PORT_D=1.
  - Latency counter width constant: $clog2(MEM_LAT+1).
- Sub-module mips_rr_arbiter2: 2-way round-robin arbiter with pointer flop and an advance input. Output is a one-hot grant.

Test Plan:
- I-only fetch at 0x0000_0010, mem word 4 = 0x2008_0005, MEM_LAT=1:
  - mem_en pulses with mem_addr=4 in cycle N+1.
  - i_rsp_valid pulses in N+3 with data 0x2008_0005; d_rsp_valid stays 0.
- D store to 0x40 with data 0xDEAD_BEEF, then D load from 0x40:
  - Store gives mem_we=1 and mem_addr=0x10, then d_rsp_valid with data 0.
  - Load returns 0xDEAD_BEEF.
- I and D valid every cycle for 8 transactions after reset: grants strictly alternate I, D, I, D, …, and I is granted first.
- MEM_LAT=3, I fetch: i_rsp_valid arrives exactly 5 cycles after the handshake; no ready is asserted during ISSUE, WAIT or RESP.
- Reset asserted during WAIT of a D load:
  - All outputs go to 0 immediately; no d_rsp_valid ever appears for that load.
  - The next request after reset release is I-favoured.
- With MIPS_ARB_STATS_EN, 3 contended rounds (6 transactions): stat_i_grants=3, stat_d_grants=3, stat_conflicts=3 (I granted, then D granted while I is not requesting). Without the macro, all three read 0.
